// File: rtl/aes_uart_pkg.sv
// Shared definitions for the AES test chip host UART link (receive and transmit paths).
package aes_uart_pkg;

  localparam int UART_BITS       = 8;
  localparam int DEFAULT_CLK_DIV = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchroniser, framing FSM and mid-bit sampling counters.
module uart_rx_byte
  import aes_uart_pkg::*;
#(
  parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rx_i,
  output logic [UART_BITS-1:0] byte_o,
  output logic                 byte_valid_o,
  output logic                 frame_err_o,
  output logic                 line_idle_o
);

  localparam int CNT_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(UART_BITS);

  rx_state_e            state_q, state_d;
  logic [1:0]           sync_q;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_idx_q, bit_idx_d;
  logic [UART_BITS-1:0] shift_q, shift_d;
  logic                 rx_s;
  logic                 half_tick;
  logic                 bit_tick;

  assign rx_s      = sync_q[1];
  assign half_tick = (cnt_q == CNT_W'(CLK_DIV / 2 - 1));
  assign bit_tick  = (cnt_q == CNT_W'(CLK_DIV - 1));

  // Synchroniser presets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q    <= 2'b11;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      sync_q    <= {sync_q[0], rx_i};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CNT_W'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_o = 1'b0;
    frame_err_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      // A start bit that is high again at its midpoint was a glitch and is ignored silently.
      START: begin
        if (half_tick) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[UART_BITS-1:1]};
          if (bit_idx_q == BIT_W'(UART_BITS - 1)) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (bit_tick) begin
          cnt_d = '0;
          if (rx_s) begin
            byte_valid_o = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_err_o = 1'b1;
            state_d     = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign byte_o      = shift_q;
  assign line_idle_o = (state_q == IDLE) && rx_s;

endmodule

// File: rtl/uart_block_rx.sv
// Packs received UART bytes into BLOCK_BYTES-wide blocks for the AES core, with a
// single-entry valid/ready output register, overrun detection and a partial-block timeout.
module uart_block_rx
  import aes_uart_pkg::*;
#(
  parameter int CLK_DIV      = DEFAULT_CLK_DIV,
  parameter int BLOCK_BYTES  = 16,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic                           io_clk,
  input  logic                           io_reset,
  input  logic                           io_rx,
  output logic [UART_BITS*BLOCK_BYTES-1:0] blk_data,
  output logic                           blk_valid,
  input  logic                           blk_ready,
  output logic                           frame_err,
  output logic                           overrun
);

  localparam int BLK_W     = UART_BITS * BLOCK_BYTES;
  localparam int BCNT_W    = (BLOCK_BYTES > 1) ? $clog2(BLOCK_BYTES) : 1;
  localparam int TO_CYCLES = TIMEOUT_BITS * CLK_DIV;
  localparam int TO_W      = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;

  logic [UART_BITS-1:0]       rx_byte;
  logic                       rx_byte_valid;
  logic                       rx_frame_err;
  logic                       line_idle;

  logic [BCNT_W-1:0]          byte_cnt_q, byte_cnt_d;
  logic [BLK_W-1:0]           asm_q, asm_d;
  logic [BLK_W-1:0]           blk_data_q, blk_data_d;
  logic                       blk_valid_q, blk_valid_d;
  logic                       frame_err_q;
  logic                       overrun_q, overrun_d;
  logic [TO_W-1:0]            to_cnt_q, to_cnt_d;
  logic [BLK_W+UART_BITS-1:0] asm_shift;
  logic [BLK_W-1:0]           asm_next;
  logic                       complete;
  logic                       to_running;

  uart_rx_byte #(
    .CLK_DIV(CLK_DIV)
  ) u_rx_byte (
    .clk_i       (io_clk),
    .rst_i       (io_reset),
    .rx_i        (io_rx),
    .byte_o      (rx_byte),
    .byte_valid_o(rx_byte_valid),
    .frame_err_o (rx_frame_err),
    .line_idle_o (line_idle)
  );

  // Oldest byte drifts towards the MSB end, so the first byte of a block lands in the top byte.
  assign asm_shift  = {asm_q, rx_byte};
  assign asm_next   = asm_shift[BLK_W-1:0];
  assign complete   = rx_byte_valid && (byte_cnt_q == BCNT_W'(BLOCK_BYTES - 1));
  assign to_running = (TIMEOUT_BITS != 0) && (byte_cnt_q != '0) && line_idle;

  always_ff @(posedge io_clk or posedge io_reset) begin
    if (io_reset) begin
      byte_cnt_q  <= '0;
      asm_q       <= '0;
      blk_data_q  <= '0;
      blk_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      to_cnt_q    <= '0;
    end else begin
      byte_cnt_q  <= byte_cnt_d;
      asm_q       <= asm_d;
      blk_data_q  <= blk_data_d;
      blk_valid_q <= blk_valid_d;
      frame_err_q <= rx_frame_err;
      overrun_q   <= overrun_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  // A completing block may replace the held one only if that one leaves in the same cycle.
  always_comb begin
    byte_cnt_d  = byte_cnt_q;
    asm_d       = asm_q;
    blk_data_d  = blk_data_q;
    blk_valid_d = blk_valid_q;
    overrun_d   = 1'b0;
    to_cnt_d    = to_cnt_q;

    if (rx_byte_valid) begin
      asm_d      = asm_next;
      byte_cnt_d = complete ? '0 : byte_cnt_q + BCNT_W'(1);
    end

    if (complete) begin
      if (!blk_valid_q || blk_ready) begin
        blk_data_d  = asm_next;
        blk_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (blk_valid_q && blk_ready) begin
      blk_valid_d = 1'b0;
    end

    // Leaving the idle line (start edge) clears the count, which is what restarts the timeout.
    if (!to_running) begin
      to_cnt_d = '0;
    end else if (to_cnt_q == TO_W'(TO_CYCLES - 1)) begin
      to_cnt_d   = '0;
      byte_cnt_d = '0;
    end else begin
      to_cnt_d = to_cnt_q + TO_W'(1);
    end
  end

  assign blk_data  = blk_data_q;
  assign blk_valid = blk_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule
